// File: rtl/ic_data_ecc_scrub_ctrl.sv
// Instruction-cache data RAM ECC controller. It serves fetch reads through an
// external combinational SECDED decoder and writes back words with a single-bit
// error. In idle cycles it runs a background scrubber. It also keeps saturating
// error counters and captures the address of the first error.
module ic_data_ecc_scrub_ctrl #(
    parameter int CNT_W          = 8,
    parameter int SCRUB_INTERVAL = 1024
) (
    input  logic             clk,
    input  logic             rst_a,
    input  logic             ecc_en,
    input  logic             scrub_en,
    input  logic             rd_req,
    input  logic [10:0]      rd_addr,
    output logic             rd_ack,
    output logic             rsp_valid,
    output logic [31:0]      rsp_data,
    output logic             rsp_err,
    output logic             ram_ce,
    output logic             ram_we,
    output logic [10:0]      ram_addr,
    output logic [39:0]      ram_wdata,
    input  logic [39:0]      ram_rdata,
    output logic             dec_enable,
    output logic [31:0]      dec_data,
    output logic [7:0]       dec_ecc,
    output logic [10:0]      dec_addr,
    input  logic [31:0]      dec_data_out,
    input  logic [7:0]       dec_ecc_out,
    input  logic             dec_single_err,
    input  logic             dec_double_err,
    input  logic             dec_addr_err,
    output logic [CNT_W-1:0] sb_cnt,
    output logic [CNT_W-1:0] db_cnt,
    input  logic             cnt_clr,
    output logic             err_addr_vld,
    output logic [10:0]      err_addr,
    input  logic             err_clr,
    output logic [1:0]       dbg_state
);

    localparam int TMR_W = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCRUB_INTERVAL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WB    = 2'd2
    } state_t;

    state_t           state;
    logic [10:0]      cur_addr;
    logic             src_fetch;
    logic [39:0]      wb_word;
    logic [10:0]      scrub_ptr;
    logic [TMR_W-1:0] timer;

    logic in_idle, in_check, in_wb;
    logic fetch_go, scrub_go;
    logic sb_ev, db_ev, err_ev;

    // Fetch handshake: the request is taken in the cycle that rd_req and
    // rd_ack are both high. rd_ack mirrors rd_req only in IDLE, outside
    // reset. The response follows exactly one cycle later in CHECK.
    assign in_idle  = rst_a && (state == ST_IDLE);
    assign in_check = (state == ST_CHECK);
    assign in_wb    = (state == ST_WB);
    assign fetch_go = in_idle && rd_req;
    assign scrub_go = in_idle && !rd_req && scrub_en && (timer == TMR_LAST);

    // Error classes are sampled only in CHECK and only when ECC is enabled.
    // An uncorrectable indication overrides a simultaneous single-bit flag.
    assign db_ev  = in_check && ecc_en && (dec_double_err || dec_addr_err);
    assign sb_ev  = in_check && ecc_en && dec_single_err && !(dec_double_err || dec_addr_err);
    assign err_ev = sb_ev || db_ev;

    assign dec_enable = ecc_en;
    assign dec_data   = ram_rdata[31:0];
    assign dec_ecc    = ram_rdata[39:32];
    assign dec_addr   = cur_addr;
    assign dbg_state  = state;

    // RAM port and response outputs decoded from the current state.
    always_comb begin
        rd_ack    = fetch_go;
        ram_ce    = fetch_go || scrub_go || in_wb;
        ram_we    = in_wb;
        ram_addr  = 11'd0;
        ram_wdata = 40'd0;
        if (in_wb) begin
            ram_addr  = cur_addr;
            ram_wdata = wb_word;
        end else if (fetch_go) begin
            ram_addr = rd_addr;
        end else if (scrub_go) begin
            ram_addr = scrub_ptr;
        end
        rsp_valid = in_check && src_fetch;
        rsp_data  = rsp_valid ? dec_data_out : 32'd0;
        rsp_err   = rsp_valid && db_ev;
    end

    // Main sequencer: IDLE issues a read, CHECK evaluates it, and WB writes back the repair.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state     <= ST_IDLE;
            cur_addr  <= 11'd0;
            src_fetch <= 1'b0;
            wb_word   <= 40'd0;
            scrub_ptr <= 11'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fetch_go) begin
                        cur_addr  <= rd_addr;
                        src_fetch <= 1'b1;
                        state     <= ST_CHECK;
                    end else if (scrub_go) begin
                        cur_addr  <= scrub_ptr;
                        src_fetch <= 1'b0;
                        state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (sb_ev) begin
                        wb_word <= {dec_ecc_out, dec_data_out};
                        state   <= ST_WB;
                    end else begin
                        state <= ST_IDLE;
                    end
                    if (!src_fetch) begin
                        scrub_ptr <= scrub_ptr + 11'd1;
                    end
                end
                ST_WB: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Scrub timer: it counts free IDLE cycles and holds at expiry until the scrub issues.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            timer <= '0;
        end else if (!scrub_en || scrub_go) begin
            timer <= '0;
        end else if (in_idle && !rd_req && (timer != TMR_LAST)) begin
            timer <= timer + 1'b1;
        end
    end

    // Saturating error counters. A clear in the same cycle beats an increment.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            sb_cnt <= '0;
            db_cnt <= '0;
        end else if (cnt_clr) begin
            sb_cnt <= '0;
            db_cnt <= '0;
        end else begin
            if (sb_ev && (sb_cnt != CNT_MAX)) sb_cnt <= sb_cnt + 1'b1;
            if (db_ev && (db_cnt != CNT_MAX)) db_cnt <= db_cnt + 1'b1;
        end
    end

    // First-error capture. A new error in the same cycle as a clear is kept.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            err_addr_vld <= 1'b0;
            err_addr     <= 11'd0;
        end else if (err_ev && (!err_addr_vld || err_clr)) begin
            err_addr_vld <= 1'b1;
            err_addr     <= cur_addr;
        end else if (err_clr) begin
            err_addr_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ic_data_ecc_scrub_ctrl.sv
// Directed bench for ic_data_ecc_scrub_ctrl. It includes a RAM model and a
// golden-copy decoder model. Inputs are driven on the falling edge, and
// outputs are checked 1 time unit later.
module tb_ic_data_ecc_scrub_ctrl;

    localparam int CNT_W          = 2;
    localparam int SCRUB_INTERVAL = 4;

    logic             clk;
    logic             rst_a;
    logic             ecc_en, scrub_en, rd_req;
    logic [10:0]      rd_addr;
    logic             rd_ack, rsp_valid, rsp_err;
    logic [31:0]      rsp_data;
    logic             ram_ce, ram_we;
    logic [10:0]      ram_addr;
    logic [39:0]      ram_wdata;
    logic [39:0]      ram_rdata = 40'd0;
    logic             dec_enable;
    logic [31:0]      dec_data;
    logic [7:0]       dec_ecc;
    logic [10:0]      dec_addr;
    logic [31:0]      dec_data_out;
    logic [7:0]       dec_ecc_out;
    logic             dec_single_err, dec_double_err, dec_addr_err;
    logic [CNT_W-1:0] sb_cnt, db_cnt;
    logic             cnt_clr;
    logic             err_addr_vld;
    logic [10:0]      err_addr;
    logic             err_clr;
    logic [1:0]       dbg_state;

    logic [39:0] mem  [0:2047];
    logic [31:0] gold [0:2047];
    logic        inj_addr_err;
    int          wr_cnt = 0;
    logic [10:0] wr_addr_last = 11'd0;
    logic [39:0] wr_data_last = 40'd0;
    logic        saw_rsp;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    ic_data_ecc_scrub_ctrl #(.CNT_W(CNT_W), .SCRUB_INTERVAL(SCRUB_INTERVAL)) dut (
        .clk(clk), .rst_a(rst_a), .ecc_en(ecc_en), .scrub_en(scrub_en),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .dec_enable(dec_enable), .dec_data(dec_data), .dec_ecc(dec_ecc),
        .dec_addr(dec_addr), .dec_data_out(dec_data_out), .dec_ecc_out(dec_ecc_out),
        .dec_single_err(dec_single_err), .dec_double_err(dec_double_err),
        .dec_addr_err(dec_addr_err), .sb_cnt(sb_cnt), .db_cnt(db_cnt),
        .cnt_clr(cnt_clr), .err_addr_vld(err_addr_vld), .err_addr(err_addr),
        .err_clr(err_clr), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ecc_of(input logic [31:0] d);
        return d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24] ^ 8'hA5;
    endfunction

    // RAM model: reads have one cycle of latency. Write-backs are logged but not stored.
    always @(posedge clk) begin
        if (ram_ce && !ram_we) ram_rdata <= mem[ram_addr];
        if (ram_ce && ram_we) begin
            wr_cnt       <= wr_cnt + 1;
            wr_addr_last <= ram_addr;
            wr_data_last <= ram_wdata;
        end
    end

    // Decoder model: it compares the word against the golden copy for dec_addr.
    logic [39:0] dec_diff;
    always_comb begin
        dec_data_out   = dec_data;
        dec_ecc_out    = dec_ecc;
        dec_single_err = 1'b0;
        dec_double_err = 1'b0;
        dec_addr_err   = 1'b0;
        dec_diff       = {dec_ecc, dec_data} ^ {ecc_of(gold[dec_addr]), gold[dec_addr]};
        if (dec_enable) begin
            if ($countones(dec_diff) == 1) begin
                dec_single_err = 1'b1;
                dec_data_out   = gold[dec_addr];
                dec_ecc_out    = ecc_of(gold[dec_addr]);
            end else if ($countones(dec_diff) > 1) begin
                dec_double_err = 1'b1;
            end
            dec_addr_err = inj_addr_err;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_word(input logic [10:0] a, input logic [31:0] d, input logic [31:0] flip);
        gold[a] = d;
        mem[a]  = {ecc_of(d), d ^ flip};
    endtask

    task automatic drive(input logic req, input logic [10:0] a);
        @(negedge clk);
        rd_req  = req;
        rd_addr = a;
        #1;
    endtask

    task automatic wait_scrub(output logic ok, output logic [10:0] a, output int gap);
        ok  = 1'b0;
        a   = 11'd0;
        gap = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            gap++;
            if (rsp_valid) saw_rsp = 1'b1;
            if (ram_ce && !ram_we) begin
                ok = 1'b1;
                a  = ram_addr;
                return;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rd_req = 1'b1;
        rd_addr = 11'h7FF;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({rd_ack, ram_ce, ram_we, rsp_valid, rsp_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 00000", {rd_ack, ram_ce, ram_we, rsp_valid, rsp_err});
        end
        checks++;
        if ({sb_cnt, db_cnt, err_addr_vld, dbg_state} !== 7'b0) begin
            failures++;
            $display("FAIL reset_state: got %b want 0000000", {sb_cnt, db_cnt, err_addr_vld, dbg_state});
        end
        rd_req = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
    endtask

    task automatic test_clean_fetch();
        int w0;
        set_word(11'h123, 32'hDEADBEEF, 32'h0);
        w0 = wr_cnt;
        drive(1'b1, 11'h123);
        exp_q.push_back(32'hDEADBEEF);
        checks++;
        if ({rd_ack, ram_ce, ram_we, ram_addr} !== {3'b110, 11'h123}) begin
            failures++;
            $display("FAIL clean_accept: got ack/ce/we/addr %b/%b/%b/%h want 1/1/0/123", rd_ack, ram_ce, ram_we, ram_addr);
        end
        drive(1'b0, 11'h0);
        checks++;
        if ({rsp_valid, rsp_err, rd_ack} !== 3'b100 || rsp_data !== exp_q.pop_front()) begin
            failures++;
            $display("FAIL clean_rsp: got v/err/ack %b%b%b data %h want 100 deadbeef", rsp_valid, rsp_err, rd_ack, rsp_data);
        end
        drive(1'b0, 11'h0);
        checks++;
        if (rsp_valid !== 1'b0 || dbg_state !== 2'd0 || wr_cnt != w0 || sb_cnt !== 2'd0 || db_cnt !== 2'd0 || err_addr_vld !== 1'b0) begin
            failures++;
            $display("FAIL clean_after: got v=%b st=%0d wr=%0d sb=%0d db=%0d vld=%b want 0 0 %0d 0 0 0", rsp_valid, dbg_state, wr_cnt, sb_cnt, db_cnt, err_addr_vld, w0);
        end
    endtask

    task automatic test_single_err();
        int w0;
        set_word(11'h123, 32'hDEADBEEF, 32'h20);
        w0 = wr_cnt;
        drive(1'b1, 11'h123);
        exp_q.push_back(32'hDEADBEEF);
        checks++;
        if (rd_ack !== 1'b1) begin failures++; $display("FAIL sb_accept: got %b want 1", rd_ack); end
        drive(1'b1, 11'h123);
        checks++;
        if ({rsp_valid, rsp_err, rd_ack} !== 3'b100 || rsp_data !== exp_q.pop_front()) begin
            failures++;
            $display("FAIL sb_rsp: got v/err/ack %b%b%b data %h want 100 deadbeef", rsp_valid, rsp_err, rd_ack, rsp_data);
        end
        drive(1'b1, 11'h123);
        checks++;
        if ({ram_ce, ram_we, rd_ack} !== 3'b110 || ram_addr !== 11'h123 || ram_wdata !== 40'h87DEADBEEF) begin
            failures++;
            $display("FAIL sb_wb: got ce/we/ack %b%b%b addr %h wdata %h want 110 123 87deadbeef", ram_ce, ram_we, rd_ack, ram_addr, ram_wdata);
        end
        set_word(11'h123, 32'hDEADBEEF, 32'h0);
        drive(1'b1, 11'h123);
        exp_q.push_back(32'hDEADBEEF);
        checks++;
        if (rd_ack !== 1'b1 || sb_cnt !== 2'd1 || err_addr_vld !== 1'b1 || err_addr !== 11'h123) begin
            failures++;
            $display("FAIL sb_after_wb: got ack=%b sb=%0d vld=%b addr=%h want 1 1 1 123", rd_ack, sb_cnt, err_addr_vld, err_addr);
        end
        drive(1'b0, 11'h0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== exp_q.pop_front()) begin
            failures++;
            $display("FAIL sb_refetch: got v=%b err=%b data=%h want 1 0 deadbeef", rsp_valid, rsp_err, rsp_data);
        end
        drive(1'b0, 11'h0);
        checks++;
        if (wr_cnt != w0 + 1 || wr_addr_last !== 11'h123 || wr_data_last !== 40'h87DEADBEEF || sb_cnt !== 2'd1) begin
            failures++;
            $display("FAIL sb_writes: got wr=%0d addr=%h data=%h sb=%0d want %0d 123 87deadbeef 1", wr_cnt, wr_addr_last, wr_data_last, sb_cnt, w0 + 1);
        end
    endtask

    task automatic test_double_err();
        int w0;
        set_word(11'h200, 32'h12345678, 32'h300);
        w0 = wr_cnt;
        drive(1'b1, 11'h200);
        drive(1'b0, 11'h0);
        checks++;
        if ({rsp_valid, rsp_err} !== 2'b11) begin
            failures++;
            $display("FAIL db_rsp: got v/err %b%b want 11", rsp_valid, rsp_err);
        end
        drive(1'b0, 11'h0);
        checks++;
        if (ram_we !== 1'b0 || dbg_state !== 2'd0 || db_cnt !== 2'd1 || err_addr !== 11'h123) begin
            failures++;
            $display("FAIL db_after: got we=%b st=%0d db=%0d err_addr=%h want 0 0 1 123", ram_we, dbg_state, db_cnt, err_addr);
        end
        set_word(11'h201, 32'hCAFEF00D, 32'h0);
        inj_addr_err = 1'b1;
        drive(1'b1, 11'h201);
        drive(1'b0, 11'h0);
        checks++;
        if ({rsp_valid, rsp_err} !== 2'b11 || rsp_data !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL addr_err_rsp: got v/err %b%b data %h want 11 cafef00d", rsp_valid, rsp_err, rsp_data);
        end
        drive(1'b0, 11'h0);
        inj_addr_err = 1'b0;
        checks++;
        if (db_cnt !== 2'd2 || sb_cnt !== 2'd1 || wr_cnt != w0) begin
            failures++;
            $display("FAIL addr_err_cnt: got db=%0d sb=%0d wr=%0d want 2 1 %0d", db_cnt, sb_cnt, wr_cnt, w0);
        end
    endtask

    task automatic test_back_to_back();
        set_word(11'h040, 32'hA5A5A5A5, 32'h0);
        set_word(11'h041, 32'h5A5A5A5A, 32'h0);
        drive(1'b1, 11'h040);
        exp_q.push_back(32'hA5A5A5A5);
        checks++;
        if (rd_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack0: got %b want 1", rd_ack); end
        drive(1'b1, 11'h041);
        checks++;
        if (rd_ack !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== exp_q.pop_front()) begin
            failures++;
            $display("FAIL b2b_rsp0: got ack=%b v=%b data=%h want 0 1 a5a5a5a5", rd_ack, rsp_valid, rsp_data);
        end
        drive(1'b1, 11'h041);
        exp_q.push_back(32'h5A5A5A5A);
        checks++;
        if (rd_ack !== 1'b1 || ram_addr !== 11'h041) begin
            failures++;
            $display("FAIL b2b_ack1: got ack=%b addr=%h want 1 041", rd_ack, ram_addr);
        end
        drive(1'b0, 11'h0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_q.pop_front()) begin
            failures++;
            $display("FAIL b2b_rsp1: got v=%b data=%h want 1 5a5a5a5a", rsp_valid, rsp_data);
        end
        drive(1'b0, 11'h0);
        checks++;
        if (rsp_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_drain: got v=%b q=%0d want 0 0", rsp_valid, exp_q.size());
        end
    endtask

    task automatic test_saturation();
        logic [31:0] flip;
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        checks++;
        if (sb_cnt !== 2'd0 || db_cnt !== 2'd0) begin
            failures++;
            $display("FAIL cnt_clr: got sb=%0d db=%0d want 0 0", sb_cnt, db_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            flip = 32'h1 << i;
            set_word(11'h010 + 11'(i), 32'h10000000 + 32'(i), flip);
            drive(1'b1, 11'h010 + 11'(i));
            drive(1'b0, 11'h0);
            drive(1'b0, 11'h0);
            drive(1'b0, 11'h0);
            if (i == 1) begin
                checks++;
                if (sb_cnt !== 2'd2) begin failures++; $display("FAIL sb_count2: got %0d want 2", sb_cnt); end
            end
        end
        checks++;
        if (sb_cnt !== 2'd3 || db_cnt !== 2'd0) begin
            failures++;
            $display("FAIL sb_saturate: got sb=%0d db=%0d want 3 0", sb_cnt, db_cnt);
        end
        set_word(11'h015, 32'h00000077, 32'h1);
        drive(1'b1, 11'h015);
        @(negedge clk);
        rd_req = 1'b0;
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        checks++;
        if (sb_cnt !== 2'd0 || db_cnt !== 2'd0) begin
            failures++;
            $display("FAIL clr_beats_inc: got sb=%0d db=%0d want 0 0", sb_cnt, db_cnt);
        end
        drive(1'b0, 11'h0);
    endtask

    task automatic test_err_capture();
        set_word(11'h050, 32'h50505050, 32'h80000000);
        drive(1'b1, 11'h050);
        @(negedge clk);
        rd_req = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        checks++;
        if (err_addr_vld !== 1'b1 || err_addr !== 11'h050 || ram_we !== 1'b1) begin
            failures++;
            $display("FAIL clr_with_err: got vld=%b addr=%h we=%b want 1 050 1", err_addr_vld, err_addr, ram_we);
        end
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        checks++;
        if (err_addr_vld !== 1'b0) begin failures++; $display("FAIL err_clr: got vld=%b want 0", err_addr_vld); end
    endtask

    task automatic test_scrub();
        logic        ok;
        logic [10:0] a;
        int          gap;
        logic [10:0] a_last;
        logic [10:0] a_wrap;
        logic        all_ok;
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        rd_req = 1'b0;
        scrub_en = 1'b1;
        saw_rsp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_scrub(ok, a, gap);
            checks++;
            if (!ok || a !== 11'(k)) begin
                failures++;
                $display("FAIL scrub_addr%0d: got ok=%b addr=%h want 1 %h", k, ok, a, 11'(k));
            end
            if (k == 2) begin
                checks++;
                if (gap != 5) begin failures++; $display("FAIL scrub_gap: got %0d want 5", gap); end
            end
        end
        all_ok = 1'b1;
        a_last = 11'd0;
        a_wrap = 11'h7FF;
        for (int k = 3; k <= 2048; k++) begin
            wait_scrub(ok, a, gap);
            if (!ok) begin
                all_ok = 1'b0;
                break;
            end
            if (k == 2047) a_last = a;
            if (k == 2048) a_wrap = a;
        end
        checks++;
        if (!all_ok || a_last !== 11'h7FF || a_wrap !== 11'h000) begin
            failures++;
            $display("FAIL scrub_wrap: got ok=%b last=%h next=%h want 1 7ff 000", all_ok, a_last, a_wrap);
        end
        checks++;
        if (saw_rsp !== 1'b0 || db_cnt !== 2'd1 || sb_cnt !== 2'd3 || err_addr_vld !== 1'b1 || err_addr !== 11'h010) begin
            failures++;
            $display("FAIL scrub_errs: got rsp=%b db=%0d sb=%0d vld=%b addr=%h want 0 1 3 1 010", saw_rsp, db_cnt, sb_cnt, err_addr_vld, err_addr);
        end
        repeat (4) @(negedge clk);
        drive(1'b1, 11'h123);
        checks++;
        if (rd_ack !== 1'b1 || ram_addr !== 11'h123) begin
            failures++;
            $display("FAIL fetch_beats_scrub: got ack=%b addr=%h want 1 123", rd_ack, ram_addr);
        end
        drive(1'b0, 11'h0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL fetch_rsp_scrub: got v=%b data=%h want 1 deadbeef", rsp_valid, rsp_data);
        end
        drive(1'b0, 11'h0);
        checks++;
        if (ram_ce !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 11'h001) begin
            failures++;
            $display("FAIL scrub_follows: got ce=%b we=%b addr=%h want 1 0 001", ram_ce, ram_we, ram_addr);
        end
        scrub_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_wb();
        int w0;
        set_word(11'h300, 32'h0F0F0F0F, 32'h1);
        w0 = wr_cnt;
        drive(1'b1, 11'h300);
        drive(1'b0, 11'h0);
        drive(1'b0, 11'h0);
        checks++;
        if (ram_we !== 1'b1) begin failures++; $display("FAIL mid_wb_pre: got we=%b want 1", ram_we); end
        rst_a = 1'b0;
        #1;
        checks++;
        if ({ram_ce, ram_we} !== 2'b00 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL mid_wb_reset: got ce/we %b%b st=%0d want 00 0", ram_ce, ram_we, dbg_state);
        end
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        checks++;
        if (sb_cnt !== 2'd0 || db_cnt !== 2'd0 || err_addr_vld !== 1'b0 || rsp_valid !== 1'b0 || dbg_state !== 2'd0 || wr_cnt != w0) begin
            failures++;
            $display("FAIL mid_wb_after: got sb=%0d db=%0d vld=%b v=%b st=%0d wr=%0d want 0 0 0 0 0 %0d", sb_cnt, db_cnt, err_addr_vld, rsp_valid, dbg_state, wr_cnt, w0);
        end
    endtask

    task automatic test_ecc_off();
        int w0;
        ecc_en = 1'b0;
        set_word(11'h301, 32'h11112222, 32'h30);
        w0 = wr_cnt;
        drive(1'b1, 11'h301);
        drive(1'b0, 11'h0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'h11112212) begin
            failures++;
            $display("FAIL ecc_off_rsp: got v=%b err=%b data=%h want 1 0 11112212", rsp_valid, rsp_err, rsp_data);
        end
        drive(1'b0, 11'h0);
        drive(1'b0, 11'h0);
        checks++;
        if (sb_cnt !== 2'd0 || db_cnt !== 2'd0 || err_addr_vld !== 1'b0 || wr_cnt != w0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL ecc_off_after: got sb=%0d db=%0d vld=%b wr=%0d st=%0d want 0 0 0 %0d 0", sb_cnt, db_cnt, err_addr_vld, wr_cnt, dbg_state, w0);
        end
        ecc_en = 1'b1;
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        rst_a        = 1'b0;
        ecc_en       = 1'b1;
        scrub_en     = 1'b0;
        rd_req       = 1'b0;
        rd_addr      = 11'd0;
        cnt_clr      = 1'b0;
        err_clr      = 1'b0;
        inj_addr_err = 1'b0;
        saw_rsp      = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            gold[i] = 32'd0;
            mem[i]  = {8'hA5, 32'd0};
        end
        test_reset();
        test_clean_fetch();
        test_single_err();
        test_double_err();
        test_back_to_back();
        test_saturation();
        test_err_capture();
        test_scrub();
        test_reset_mid_wb();
        test_ecc_off();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
